// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields and pipeline control in, registered EX fields,
// stall request and performance counters out.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  typedef logic [4:0] regName_t;

  logic                  id_valid;
  regName_t              id_rs1;
  regName_t              id_rs2;
  regName_t              id_rd;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic                  id_regWrite;
  logic                  id_memRead;
  logic                  id_memWrite;
  logic [DATA_WIDTH-1:0] id_pc;
  logic [DATA_WIDTH-1:0] id_rs1_data;
  logic [DATA_WIDTH-1:0] id_rs2_data;
  logic [DATA_WIDTH-1:0] id_imm;

  logic                  ex_flush;
  logic                  mem_hold;
  logic                  stall_id;

  logic                  ex_valid;
  logic                  ex_regWrite;
  logic                  ex_memRead;
  logic                  ex_memWrite;
  regName_t              ex_rs1;
  regName_t              ex_rs2;
  regName_t              ex_rd;
  logic [DATA_WIDTH-1:0] ex_pc;
  logic [DATA_WIDTH-1:0] ex_rs1_data;
  logic [DATA_WIDTH-1:0] ex_rs2_data;
  logic [DATA_WIDTH-1:0] ex_imm;

  logic [CNT_WIDTH-1:0]  stall_cnt;
  logic [CNT_WIDTH-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_regWrite, id_memRead, id_memWrite,
           id_pc, id_rs1_data, id_rs2_data, id_imm,
           ex_flush, mem_hold,
    input  stall_id, ex_valid, ex_regWrite, ex_memRead, ex_memWrite,
           ex_rs1, ex_rs2, ex_rd, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           stall_cnt, bubble_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_regWrite, id_memRead, id_memWrite,
           id_pc, id_rs1_data, id_rs2_data, id_imm,
           ex_flush, mem_hold,
    output stall_id, ex_valid, ex_regWrite, ex_memRead, ex_memWrite,
           ex_rs1, ex_rs2, ex_rd, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and memory hold.
// Define ID_EX_PERF_CNT_EN to build the saturating stall/bubble counters.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
  } ex_bank_t;

  ex_bank_t ex_bank_q;
  ex_bank_t ex_bank_d;
  logic     load_use;
  logic     stall_id;
  logic     bubble;

  // A load still in EX cannot forward to its consumer in ID; a load to x0 never matters.
  always_comb begin
    load_use = ex_bank_q.valid && ex_bank_q.mem_read && (ex_bank_q.rd != 5'd0) &&
               bus.id_valid &&
               ((bus.id_use_rs1 && (bus.id_rs1 == ex_bank_q.rd)) ||
                (bus.id_use_rs2 && (bus.id_rs2 == ex_bank_q.rd)));
    stall_id = (load_use || bus.mem_hold) && !bus.ex_flush;
  end

  always_comb begin
    ex_bank_d = ex_bank_q;
    bubble    = 1'b0;
    if (bus.ex_flush) begin
      ex_bank_d = '0;
      bubble    = 1'b1;
    end else if (bus.mem_hold) begin
      ex_bank_d = ex_bank_q;
    end else if (load_use) begin
      ex_bank_d = '0;
      bubble    = 1'b1;
    end else begin
      ex_bank_d.valid     = bus.id_valid;
      ex_bank_d.reg_write = bus.id_regWrite && bus.id_valid;
      ex_bank_d.mem_read  = bus.id_memRead && bus.id_valid;
      ex_bank_d.mem_write = bus.id_memWrite && bus.id_valid;
      ex_bank_d.rs1       = bus.id_rs1;
      ex_bank_d.rs2       = bus.id_rs2;
      ex_bank_d.rd        = bus.id_rd;
      ex_bank_d.pc        = bus.id_pc;
      ex_bank_d.rs1_data  = bus.id_rs1_data;
      ex_bank_d.rs2_data  = bus.id_rs2_data;
      ex_bank_d.imm       = bus.id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_bank_q <= '0;
    end else begin
      ex_bank_q <= ex_bank_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] stall_cnt_d;
  logic [CNT_WIDTH-1:0] bubble_cnt_q;
  logic [CNT_WIDTH-1:0] bubble_cnt_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_id && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`else
  logic unused_bubble;
  assign unused_bubble  = bubble;
  assign bus.stall_cnt  = '0;
  assign bus.bubble_cnt = '0;
`endif

  assign bus.stall_id    = stall_id;
  assign bus.ex_valid    = ex_bank_q.valid;
  assign bus.ex_regWrite = ex_bank_q.reg_write;
  assign bus.ex_memRead  = ex_bank_q.mem_read;
  assign bus.ex_memWrite = ex_bank_q.mem_write;
  assign bus.ex_rs1      = ex_bank_q.rs1;
  assign bus.ex_rs2      = ex_bank_q.rs2;
  assign bus.ex_rd       = ex_bank_q.rd;
  assign bus.ex_pc       = ex_bank_q.pc;
  assign bus.ex_rs1_data = ex_bank_q.rs1_data;
  assign bus.ex_rs2_data = ex_bank_q.rs2_data;
  assign bus.ex_imm      = ex_bank_q.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use bubble, false-stall cases, hold,
// flush priority, reset mid-stall and counter saturation (CNT_WIDTH=4).
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 4;
`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  id_ex_stage_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  id_ex_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one ID instruction; inputs settle before the comb checks.
  task automatic applyStimulus(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic use1, input logic use2,
                               input logic rw, input logic mr, input logic mw,
                               input logic [31:0] pc);
    bus.id_valid    = valid;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_use_rs1  = use1;
    bus.id_use_rs2  = use2;
    bus.id_regWrite = rw;
    bus.id_memRead  = mr;
    bus.id_memWrite = mw;
    bus.id_pc       = pc;
    bus.id_rs1_data = pc ^ 32'hA5A5_0000;
    bus.id_rs2_data = pc ^ 32'h0000_5A5A;
    bus.id_imm      = pc + 32'd16;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] cnt(input int n);
    return PERF ? 64'(n) : 64'd0;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ex_flush = 1'b0;
    bus.mem_hold = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("[TB] reset with random inputs");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1,
                    1'b1, 1'($urandom), 1'($urandom), $urandom);
      bus.ex_flush = 1'($urandom);
      tick();
    end
    bus.ex_flush = 1'b0;
    checkOutput("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
    checkOutput("rst_ex_regWrite", 64'(bus.ex_regWrite), 64'd0);
    checkOutput("rst_ex_rd", 64'(bus.ex_rd), 64'd0);
    checkOutput("rst_ex_pc", 64'(bus.ex_pc), 64'd0);
    checkOutput("rst_ex_rs1_data", 64'(bus.ex_rs1_data), 64'd0);
    checkOutput("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    checkOutput("rst_bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
    checkOutput("rst_stall_id", 64'(bus.stall_id), 64'd0);
    rst = 1'b0;

    $display("[TB] load-use: lw x5 then add x6,x5,x7");
    applyStimulus(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100);
    checkOutput("lw_stall_id", 64'(bus.stall_id), 64'd0);
    tick();
    checkOutput("lw_ex_memRead", 64'(bus.ex_memRead), 64'd1);
    checkOutput("lw_ex_rd", 64'(bus.ex_rd), 64'd5);
    checkOutput("lw_ex_pc", 64'(bus.ex_pc), 64'h100);
    checkOutput("lw_ex_imm", 64'(bus.ex_imm), 64'h110);
    applyStimulus(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h104);
    checkOutput("lu_stall_id", 64'(bus.stall_id), 64'd1);
    tick();
    checkOutput("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
    checkOutput("lu_bubble_rd", 64'(bus.ex_rd), 64'd0);
    checkOutput("lu_bubble_regWrite", 64'(bus.ex_regWrite), 64'd0);
    checkOutput("lu_bubble_pc", 64'(bus.ex_pc), 64'd0);
    checkOutput("lu_stall_released", 64'(bus.stall_id), 64'd0);
    tick();
    checkOutput("add_ex_valid", 64'(bus.ex_valid), 64'd1);
    checkOutput("add_ex_rd", 64'(bus.ex_rd), 64'd6);
    checkOutput("add_ex_rs1", 64'(bus.ex_rs1), 64'd5);
    checkOutput("add_ex_rs2_data", 64'(bus.ex_rs2_data), 64'(32'h104 ^ 32'h0000_5A5A));
    checkOutput("lu_bubble_cnt", 64'(bus.bubble_cnt), cnt(1));
    checkOutput("lu_stall_cnt", 64'(bus.stall_cnt), cnt(1));

    $display("[TB] no false stall: load to x0, unused rs2");
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h108);
    tick();
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10C);
    checkOutput("x0_stall_id", 64'(bus.stall_id), 64'd0);
    tick();
    checkOutput("x0_ex_rd", 64'(bus.ex_rd), 64'd8);
    checkOutput("x0_ex_valid", 64'(bus.ex_valid), 64'd1);
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h110);
    tick();
    applyStimulus(1'b1, 5'd3, 5'd5, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h114);
    checkOutput("rs2unused_stall_id", 64'(bus.stall_id), 64'd0);
    tick();
    checkOutput("rs2unused_ex_rd", 64'(bus.ex_rd), 64'd9);
    checkOutput("rs2unused_ex_pc", 64'(bus.ex_pc), 64'h114);
    applyStimulus(1'b0, 5'd3, 5'd4, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h118);
    tick();
    checkOutput("invalid_ex_valid", 64'(bus.ex_valid), 64'd0);
    checkOutput("invalid_ex_regWrite", 64'(bus.ex_regWrite), 64'd0);
    checkOutput("invalid_ex_memWrite", 64'(bus.ex_memWrite), 64'd0);

    $display("[TB] memory hold for 3 cycles");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200);
    tick();
    bus.mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd3, 5'd4, 5'(12 + i), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300 + 32'(4 * i));
      checkOutput("hold_stall_id", 64'(bus.stall_id), 64'd1);
      tick();
      checkOutput("hold_ex_pc", 64'(bus.ex_pc), 64'h200);
      checkOutput("hold_ex_rd", 64'(bus.ex_rd), 64'd11);
    end
    bus.mem_hold = 1'b0;
    #1;
    checkOutput("hold_release_stall_id", 64'(bus.stall_id), 64'd0);
    checkOutput("hold_stall_cnt", 64'(bus.stall_cnt), cnt(3));

    $display("[TB] hold together with load-use");
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400);
    tick();
    bus.mem_hold = 1'b1;
    applyStimulus(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h404);
    checkOutput("holdlu_stall_id", 64'(bus.stall_id), 64'd1);
    tick();
    checkOutput("holdlu_ex_rd", 64'(bus.ex_rd), 64'd5);
    checkOutput("holdlu_ex_memRead", 64'(bus.ex_memRead), 64'd1);
    checkOutput("holdlu_bubble_cnt", 64'(bus.bubble_cnt), cnt(0));

    $display("[TB] flush over load-use and hold");
    bus.ex_flush = 1'b1;
    #1;
    checkOutput("flush_stall_id", 64'(bus.stall_id), 64'd0);
    tick();
    checkOutput("flush_ex_valid", 64'(bus.ex_valid), 64'd0);
    checkOutput("flush_ex_regWrite", 64'(bus.ex_regWrite), 64'd0);
    checkOutput("flush_ex_rd", 64'(bus.ex_rd), 64'd0);
    checkOutput("flush_bubble_cnt", 64'(bus.bubble_cnt), cnt(1));
    checkOutput("flush_stall_cnt", 64'(bus.stall_cnt), cnt(4));
    bus.ex_flush = 1'b0;
    bus.mem_hold = 1'b0;

    $display("[TB] reset during a load-use stall");
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h500);
    tick();
    applyStimulus(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h504);
    checkOutput("rststall_pre_stall_id", 64'(bus.stall_id), 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("rststall_ex_valid", 64'(bus.ex_valid), 64'd0);
    checkOutput("rststall_stall_id", 64'(bus.stall_id), 64'd0);
    checkOutput("rststall_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    rst = 1'b0;

    $display("[TB] 20 hold cycles for counter saturation");
    bus.mem_hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    checkOutput("sat_stall_cnt", 64'(bus.stall_cnt), cnt(15));
    bus.mem_hold = 1'b0;
    tick();
    checkOutput("sat_stall_cnt_held", 64'(bus.stall_cnt), cnt(15));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the 5-stage RV32I core, with load-use hazard detection and pipeline-control sequencing. It captures decoded operands and control from the ID stage and presents them to EX, where the operand-forwarding logic consumes `ex_rs1`, `ex_rs2`, `ex_rd` and `ex_regWrite`. When a load in EX feeds the instruction in ID, the block stalls ID and inserts a bubble, because forwarding cannot cover that case. It also applies branch flushes and whole-pipeline memory holds.

## Interface
- `DATA_WIDTH`, 32, operand/PC/immediate width
- `CNT_WIDTH`, 16, width of the stall/bubble performance counters
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_valid`  in  1  ID holds a real instruction
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register names (`regName_t`)
- `id_use_rs1`, `id_use_rs2`  in  1 each  instruction actually reads rs1/rs2
- `id_regWrite`, `id_memRead`, `id_memWrite`  in  1 each  decoded control
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`  in  DATA_WIDTH each  datapath fields
- `ex_flush`  in  1  branch/jump taken in EX; kill the ID instruction
- `mem_hold`  in  1  data memory busy; freeze the whole pipeline
- `stall_id`  out  1  hold the PC and the IF/ID register this cycle
- `ex_valid`, `ex_regWrite`, `ex_memRead`, `ex_memWrite`  out  1 each  registered control
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5 each  registered register names
- `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`  out  DATA_WIDTH each  registered datapath fields
- `stall_cnt`, `bubble_cnt`  out  CNT_WIDTH each  performance counters

## Operation
- Load-use hazard (combinational):
  - `lu = ex_valid & ex_memRead & (ex_rd!=0) & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))`.
- `stall_id = (lu | mem_hold) & ~ex_flush`.
- Per-edge update of the EX register bank, first matching rule wins:
  1. `rst`: all `ex_*` outputs and both counters cleared to 0.
  2. `ex_flush`: bubble. `ex_valid`, `ex_regWrite`, `ex_memRead` and `ex_memWrite` go to 0. Datapath fields and register names also go to 0.
  3. `mem_hold`: all `ex_*` hold their values.
  4. `lu`: bubble, identical to rule 2.
  5. Otherwise: load all ID fields. Control bits are ANDed with `id_valid`, so an invalid ID never writes.
- The bubble forces `ex_rd=0`, so forwarding never matches a bubble.
- A stalled instruction re-evaluates `lu` every cycle. A load-use stall lasts exactly 1 cycle, because the load moves to MEM.
- State is implicit: the register bank plus the counters; there is no FSM beyond this.

## Timing
- Latency is 1 cycle: ID fields sampled at edge N appear on `ex_*` after edge N.
- `stall_id` is combinational from current `ex_*` and `id_*` and is valid in the same cycle.
- Back-to-back loads into dependent instructions cause one bubble per dependency, never two in a row for the same pair.
- `mem_hold` together with `lu`: hold wins, no bubble is inserted, and `stall_id` stays high.
- `ex_flush` together with `lu` or `mem_hold`: flush wins, `stall_id` is 0, and a bubble enters EX.
- Reset mid-stall: the next cycle has `ex_valid=0` and `stall_id=0`, unless `mem_hold` is high.
- All outputs are 0 after reset, and `stall_id` is 0 whenever `mem_hold` is 0.

## Configuration
- `ID_EX_PERF_CNT_EN` defined:
  - `stall_cnt` increments on every edge where `stall_id=1` and `rst=0`.
  - `bubble_cnt` increments on every edge where rule 2 or rule 4 applies.
  - Both counters saturate at `2^CNT_WIDTH-1`; there is no wrap.
- Not defined: counters are not instantiated and both outputs are tied to 0.

## Test plan
- Reset:
  - Stimulus: assert `rst` for 2 cycles with random inputs.
  - Required response: all `ex_*`, `stall_cnt` and `bubble_cnt` are 0, and `stall_id=0`.
- Load-use:
  - Stimulus: `lw x5` in EX (`ex_memRead=1`, `ex_rd=5`), `add x6,x5,x7` in ID.
  - Required response: `stall_id=1` for 1 cycle and `ex_valid=0` with `ex_rd=0` next. The `add` enters EX the cycle after, and `bubble_cnt=1`.
- No false stall:
  - Stimulus: a load to `x0`, or a load to x5 followed by an instruction with `id_use_rs2=0`, `id_rs2=5`.
  - Required response: `stall_id=0` and the instruction passes through.
- Memory hold:
  - Stimulus: `mem_hold=1` for 3 cycles with changing `id_*`.
  - Required response: `ex_*` is unchanged for 3 edges, `stall_id=1`, and `stall_cnt=3`.
- Flush priority:
  - Stimulus: `ex_flush=1` together with `lu=1` and `mem_hold=1`.
  - Required response: `stall_id=0`, the next `ex_valid=0`, and `ex_regWrite=0`.
- Saturation (`CNT_WIDTH=4`, macro on):
  - Stimulus: 20 stall cycles.
  - Required response: `stall_cnt` holds at 15.
